// File: rtl/pulse_pkg.sv
// Shared constants, types and helpers for the
// pulse generator parameter path.
package pulse_pkg;

  localparam logic [7:0] FRAME_HDR = 8'hA5;

  localparam logic [7:0] A_PERIOD  = 8'h00;
  localparam logic [7:0] A_P1WIDTH = 8'h01;
  localparam logic [7:0] A_DELAY   = 8'h02;
  localparam logic [7:0] A_P2WIDTH = 8'h03;
  localparam logic [7:0] A_PBWIDTH = 8'h04;
  localparam logic [7:0] A_OFFRES  = 8'h05;
  localparam logic [7:0] A_ATT     = 8'h06;
  localparam logic [7:0] A_FLAGS   = 8'h07;
  localparam logic [7:0] A_COMMIT  = 8'h0F;

  localparam int SAT_W = 33;

  typedef enum logic [2:0] {
    IDLE, ADDR, D3, D2, D1, D0, CHK
  } rx_state_t;

  typedef struct packed {
    logic [31:0] period;
    logic [31:0] p1width;
    logic [31:0] p2start;
    logic [31:0] sync_up;
    logic [31:0] pbwidth;
    logic [31:0] att_down;
    logic [31:0] delay;
    logic [31:0] offres_delay;
    logic [6:0]  pp_pump;
    logic [6:0]  pp_probe;
    logic [6:0]  post_att;
    logic [7:0]  pulse_block;
    logic        pump;
    logic        dbl;
    logic        block;
  } pulse_cfg_t;

  function automatic logic [31:0] sat_add(
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic [SAT_W-1:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[SAT_W-1] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

endpackage

// File: rtl/pulse_frame_rx.sv
// Byte-stream frame receiver: header sync,
// checksum and inter-byte timeout.
module pulse_frame_rx
  import pulse_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic        clk_pll,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  addr,
  output logic [31:0] data,
  output logic        valid,
  output logic        err
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] GAP_MAX =
    CW'(TIMEOUT_CYCLES - 1);

  rx_state_t state, state_n;
  logic [CW-1:0] gap;
  logic [7:0] chk;
  logic tmo;

  assign tmo = (state != IDLE) && !rx_valid
            && (gap == GAP_MAX);

  always_comb begin
    state_n = state;
    if (tmo) begin
      state_n = IDLE;
    end else if (rx_valid) begin
      unique case (state)
        IDLE: if (rx_data == FRAME_HDR) state_n = ADDR;
        ADDR: state_n = D3;
        D3:   state_n = D2;
        D2:   state_n = D1;
        D1:   state_n = D0;
        D0:   state_n = CHK;
        CHK:  state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_pll or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge clk_pll or posedge reset) begin
    if (reset) begin
      gap   <= '0;
      addr  <= '0;
      data  <= '0;
      chk   <= '0;
      valid <= 1'b0;
      err   <= 1'b0;
    end else begin
      valid <= 1'b0;
      err   <= tmo;
      if (rx_valid || state == IDLE) gap <= '0;
      else gap <= gap + CW'(1);
      if (rx_valid) begin
        unique case (state)
          ADDR: begin
            addr <= rx_data;
            chk  <= rx_data;
          end
          D3, D2, D1, D0: begin
            data <= {data[23:0], rx_data};
            chk  <= chk ^ rx_data;
          end
          CHK: begin
            valid <= (chk == rx_data);
            err   <= (chk != rx_data);
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/pulse_param_loader.sv
// Shadow registers, derived-timing pipeline and
// cycle-boundary apply of the pulse parameters.
module pulse_param_loader
  import pulse_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 200000,
  parameter logic [31:0] DEF_PERIOD  = 32'd2000000,
  parameter logic [31:0] DEF_P1WIDTH = 32'd40,
  parameter logic [31:0] DEF_DELAY   = 32'd2000,
  parameter logic [31:0] DEF_P2WIDTH = 32'd80
) (
  input  logic        clk_pll,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        sync_on,
  output logic [31:0] period,
  output logic [31:0] p1width,
  output logic [31:0] p2start,
  output logic [31:0] sync_up,
  output logic [31:0] pbwidth,
  output logic [31:0] att_down,
  output logic [31:0] delay,
  output logic [31:0] offres_delay,
  output logic [6:0]  pp_pump,
  output logic [6:0]  pp_probe,
  output logic [6:0]  post_att,
  output logic [7:0]  pulse_block,
  output logic        pump,
  output logic        double,
  output logic        block,
  output logic        pending,
  output logic        frame_ok,
  output logic        frame_err,
  output logic        cfg_err
);

  localparam logic [31:0] DEF_P2S =
    sat_add(DEF_P1WIDTH, DEF_DELAY);
  localparam logic [31:0] DEF_SU =
    sat_add(DEF_P2S, DEF_P2WIDTH);
  localparam logic [31:0] DEF_AD =
    sat_add(DEF_SU, DEF_DELAY);

  localparam pulse_cfg_t DEF_CFG = '{
    period: DEF_PERIOD, p1width: DEF_P1WIDTH,
    p2start: DEF_P2S, sync_up: DEF_SU,
    pbwidth: 32'd0, att_down: DEF_AD,
    delay: DEF_DELAY, offres_delay: 32'd0,
    pp_pump: 7'd0, pp_probe: 7'd0, post_att: 7'd0,
    pulse_block: 8'd0,
    pump: 1'b0, dbl: 1'b0, block: 1'b0
  };

  logic [7:0]  f_addr;
  logic [31:0] f_data;
  logic        f_valid;

  pulse_frame_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk_pll  (clk_pll),
    .reset    (reset),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .addr     (f_addr),
    .data     (f_data),
    .valid    (f_valid),
    .err      (frame_err)
  );

  assign frame_ok = f_valid;

  logic [31:0] period_sh, p1w_sh, delay_sh;
  logic [31:0] p2w_sh, pbw_sh, offres_sh;
  logic [6:0]  pump_sh, probe_sh, post_sh;
  logic [7:0]  pblock_sh;
  logic [2:0]  flags_sh;

  always_ff @(posedge clk_pll or posedge reset) begin
    if (reset) begin
      period_sh <= DEF_PERIOD;
      p1w_sh    <= DEF_P1WIDTH;
      delay_sh  <= DEF_DELAY;
      p2w_sh    <= DEF_P2WIDTH;
      pbw_sh    <= '0;
      offres_sh <= '0;
      pump_sh   <= '0;
      probe_sh  <= '0;
      post_sh   <= '0;
      pblock_sh <= '0;
      flags_sh  <= '0;
    end else if (f_valid) begin
      case (f_addr)
        A_PERIOD:  period_sh <= f_data;
        A_P1WIDTH: p1w_sh    <= f_data;
        A_DELAY:   delay_sh  <= f_data;
        A_P2WIDTH: p2w_sh    <= f_data;
        A_PBWIDTH: pbw_sh    <= f_data;
        A_OFFRES:  offres_sh <= f_data;
        A_ATT: begin
          pump_sh  <= f_data[30:24];
          probe_sh <= f_data[23:17];
          post_sh  <= f_data[16:10];
        end
        A_FLAGS: begin
          pblock_sh <= f_data[15:8];
          flags_sh  <= f_data[2:0];
        end
        default: ;
      endcase
    end
  end

  pulse_cfg_t snap, s1_cfg, s2_cfg, s2_n;
  pulse_cfg_t staged, act;
  logic [31:0] s1_p2w;
  logic s1_vld, s2_vld, s1_now, s2_now;
  logic now_q, commit, s2_ok, apply;
  logic [1:0] sync_q;
  logic sync_edge;

  assign commit = f_valid && (f_addr == A_COMMIT);

  // Stage 1 snapshots every shadow at once, so
  // later frames cannot leak into this commit.
  always_comb begin
    snap = '{
      period: period_sh, p1width: p1w_sh,
      p2start: sat_add(p1w_sh, delay_sh),
      sync_up: 32'd0, pbwidth: pbw_sh,
      att_down: 32'd0, delay: delay_sh,
      offres_delay: offres_sh,
      pp_pump: pump_sh, pp_probe: probe_sh,
      post_att: post_sh, pulse_block: pblock_sh,
      pump: flags_sh[0], dbl: flags_sh[1],
      block: flags_sh[2]
    };
    s2_n = s1_cfg;
    s2_n.sync_up = sat_add(s1_cfg.p2start, s1_p2w);
    s2_n.att_down =
      sat_add(s2_n.sync_up, s1_cfg.delay);
  end

  always_ff @(posedge clk_pll or posedge reset) begin
    if (reset) begin
      s1_vld <= 1'b0;
      s2_vld <= 1'b0;
      s1_now <= 1'b0;
      s2_now <= 1'b0;
      s1_cfg <= DEF_CFG;
      s2_cfg <= DEF_CFG;
      s1_p2w <= '0;
    end else begin
      s1_vld <= commit;
      s2_vld <= s1_vld;
      if (commit) begin
        s1_cfg <= snap;
        s1_p2w <= p2w_sh;
        s1_now <= f_data[0];
      end
      if (s1_vld) begin
        s2_cfg <= s2_n;
        s2_now <= s1_now;
      end
    end
  end

  assign s2_ok = s2_cfg.sync_up < s2_cfg.period;
  assign sync_edge = sync_q[0] & ~sync_q[1];
  assign apply = pending && (sync_edge || now_q);

  // A stage-3 pass in the same cycle as an apply
  // wins, leaving the newer set pending.
  always_ff @(posedge clk_pll or posedge reset) begin
    if (reset) begin
      sync_q  <= '0;
      staged  <= DEF_CFG;
      act     <= DEF_CFG;
      pending <= 1'b0;
      now_q   <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], sync_on};
      cfg_err <= s2_vld && !s2_ok;
      if (apply) begin
        act     <= staged;
        pending <= 1'b0;
      end
      if (s2_vld && s2_ok) begin
        staged  <= s2_cfg;
        now_q   <= s2_now;
        pending <= 1'b1;
      end
    end
  end

  assign period       = act.period;
  assign p1width      = act.p1width;
  assign p2start      = act.p2start;
  assign sync_up      = act.sync_up;
  assign pbwidth      = act.pbwidth;
  assign att_down     = act.att_down;
  assign delay        = act.delay;
  assign offres_delay = act.offres_delay;
  assign pp_pump      = act.pp_pump;
  assign pp_probe     = act.pp_probe;
  assign post_att     = act.post_att;
  assign pulse_block  = act.pulse_block;
  assign pump         = act.pump;
  assign double       = act.dbl;
  assign block        = act.block;

endmodule
